mux_config_writer: RTL and testbench
====================================

// Module: mux_config_writer
// PURPOSE
//  Programs the selector and enable registers that drive the console GPIO mux.
//  Accepts one route request at a time on a valid/ready port and applies it with
//  break-before-make: the target output is disabled, its selector is changed, the
//  selection settles, and only then is the output re-enabled. Sits between the
//  control logic and the mux's `selectors` / `enabled_out` inputs.
// PARAMETERS
//  INPUT_COUNT   4  number of mux inputs; valid selector values are 0..INPUT_COUNT-1
//  OUTPUT_COUNT  4  number of mux outputs (route slots)
//  SEL_WIDTH     4  bits per selector field in `selectors`
//  GAP_CYCLES    2  length of the BREAK and SETTLE phases in clk cycles; must be >= 1
// PORTS
//  clk          in   1                        system clock, rising edge
//  rst_n        in   1                        asynchronous active-low reset
//  wr_valid     in   1                        route request present
//  wr_ready     out  1                        block can accept a request (state IDLE)
//  wr_out_idx   in   8                        target output index
//  wr_sel       in   SEL_WIDTH                mux input to select
//  wr_en        in   1                        final enable state for the target output
//  selectors    out  OUTPUT_COUNT*SEL_WIDTH   field k = [k*SEL_WIDTH +: SEL_WIDTH]
//  enabled_out  out  OUTPUT_COUNT             per-output enable to the mux
//  busy         out  1                        = ~wr_ready
//  done         out  1                        1-cycle pulse when a request completes
//  err          out  1                        1-cycle pulse when a request is rejected
// BEHAVIOUR
//  Reset (rst_n=0, async): state IDLE, selectors=0, enabled_out=0, done=0, err=0,
//   wr_ready=1 once rst_n deasserts. Reset mid-operation aborts the request.
//   No partial update survives reset.
//  Accept: handshake completes on the rising edge where wr_valid & wr_ready (edge E0).
//   Request fields are latched at E0; inputs are ignored afterwards.
//  Reject: if wr_out_idx >= OUTPUT_COUNT or wr_sel >= INPUT_COUNT at E0, err=1 for
//   the next cycle only. No register changes, and the state stays IDLE.
//  FSM states are IDLE, BREAK, SETTLE.
//   IDLE -> BREAK at E0 if enabled_out[idx]=1. enabled_out[idx] clears at E0.
//   IDLE -> SETTLE at E0 if enabled_out[idx]=0. The selector field is written at E0.
//   BREAK lasts GAP_CYCLES cycles, then goes to SETTLE. The selector field is written
//    on the exiting edge.
//   SETTLE lasts GAP_CYCLES cycles, then goes to IDLE. enabled_out[idx] <= wr_en on
//    the exiting edge, and done=1 for the following cycle.
//  Latency (GAP_CYCLES=G):
//   - Target was enabled: selector changes at E0+G; enable is restored and done is
//     pulsed at E0+2G.
//   - Target was disabled: selector changes at E0; done is pulsed at E0+G.
//  While busy, wr_ready=0. Other outputs' selector and enable bits never change.
//  wr_ready is asserted in the cycle done is high, so back-to-back requests are allowed.
//  A same-value request (same sel, en=1 on an enabled output) still performs the full
//   break/settle sequence. No shortcut is taken.
//  wr_en=0 request: the sequence runs normally and the output ends disabled.
//  Output stability: enabled_out[idx] is never 1 in any cycle where selector field
//   idx differs from the value it held at the last enable.
//  All outputs are registered. No combinational path runs from wr_* to selectors or
//   enabled_out.
// TESTING
//  1 Reset: assert rst_n=0 mid-BREAK, then release.
//    -> selectors=0, enabled_out=0, wr_ready=1, done=0.
//  2 Output 1 disabled; write idx=1 sel=2 en=1 (G=2).
//    -> selectors[7:4]=2 at E0; enabled_out[1]=1 and done at E0+2.
//  3 Output 1 enabled with sel=2; write idx=1 sel=3 en=1.
//    -> enabled_out[1]=0 at E0; sel=3 at E0+2; enable=1 and done at E0+4.
//    -> Checker: enable and sel never change on the same edge.
//  4 Write idx=4, then idx=0 sel=5.
//    -> err pulse each time, no register change, wr_ready stays 1.
//  5 Hold wr_valid high with requests to outputs 0 and 1.
//    -> second accept in the done cycle; outputs 2 and 3 untouched throughout.
//  6 Write idx=0 sel=1 en=0 on an enabled output.
//    -> output ends disabled with selector field 0 = 1; done asserted.

Source files
------------

// File: rtl/mux_config_writer_if.sv
// Route-request port and mux register outputs of the GPIO mux config writer.
// The master issues requests; the slave owns the selector and enable registers.
interface mux_config_writer_if #(
  parameter int OUTPUT_COUNT = 4,
  parameter int SEL_WIDTH    = 4
);
  logic                              wr_valid;
  logic                              wr_ready;
  logic [7:0]                        wr_out_idx;
  logic [SEL_WIDTH-1:0]              wr_sel;
  logic                              wr_en;
  logic [OUTPUT_COUNT*SEL_WIDTH-1:0] selectors;
  logic [OUTPUT_COUNT-1:0]           enabled_out;
  logic                              busy;
  logic                              done;
  logic                              err;

  modport master (
    output wr_valid, wr_out_idx, wr_sel, wr_en,
    input  wr_ready, selectors, enabled_out, busy, done, err
  );

  modport slave (
    input  wr_valid, wr_out_idx, wr_sel, wr_en,
    output wr_ready, selectors, enabled_out, busy, done, err
  );
endinterface

// File: rtl/mux_config_writer.sv
// Break-before-make writer for the console GPIO mux selector/enable registers.
// Done at E0+2G (target enabled) or E0+G (target disabled); wr_ready low while busy.
module mux_config_writer #(
  parameter int INPUT_COUNT  = 4,
  parameter int OUTPUT_COUNT = 4,
  parameter int SEL_WIDTH    = 4,
  parameter int GAP_CYCLES   = 2
) (
  input logic                clk,
  input logic                rst_n,
  mux_config_writer_if.slave bus
);
  localparam int IDX_W = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1;
  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BREAK, S_SETTLE} state_t;

  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic [SEL_WIDTH-1:0] sel;
    logic                 en;
  } req_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  req_t                              r_req;
  req_t                              w_req_in;
  logic [CNT_W-1:0]                  r_cnt;
  logic [OUTPUT_COUNT*SEL_WIDTH-1:0] r_selectors;
  logic [OUTPUT_COUNT-1:0]           r_enabled;
  logic                              r_done;
  logic                              r_err;
  logic                              w_req_ok;
  logic                              w_gap_end;
  logic                              w_accept;
  logic                              w_reject;
  logic                              w_load_sel;
  logic                              w_clr_en;
  logic                              w_set_en;
  logic [IDX_W-1:0]                  w_tgt_idx;
  logic [SEL_WIDTH-1:0]              w_tgt_sel;

  assign w_req_in.idx = bus.wr_out_idx[IDX_W-1:0];
  assign w_req_in.sel = bus.wr_sel;
  assign w_req_in.en  = bus.wr_en;

  assign w_req_ok  = (int'(bus.wr_out_idx) < OUTPUT_COUNT) && (int'(bus.wr_sel) < INPUT_COUNT);
  assign w_gap_end = (r_cnt == CNT_LAST);

  // In IDLE the target comes straight from the port (edge E0); later from the latched request.
  assign w_tgt_idx = (r_state == S_IDLE) ? w_req_in.idx : r_req.idx;
  assign w_tgt_sel = (r_state == S_IDLE) ? w_req_in.sel : r_req.sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_load_sel  = 1'b0;
    w_clr_en    = 1'b0;
    w_set_en    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.wr_valid) begin
          if (w_req_ok) begin
            w_accept = 1'b1;
            if (r_enabled[w_req_in.idx]) begin
              w_state_nxt = S_BREAK;
              w_clr_en    = 1'b1;
            end else begin
              w_state_nxt = S_SETTLE;
              w_load_sel  = 1'b1;
            end
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (w_gap_end) begin
          w_state_nxt = S_SETTLE;
          w_load_sel  = 1'b1;
        end
      end
      S_SETTLE: begin
        if (w_gap_end) begin
          w_state_nxt = S_IDLE;
          w_set_en    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req       <= '0;
      r_cnt       <= '0;
      r_selectors <= '0;
      r_enabled   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= w_set_en;
      r_err  <= w_reject;
      if (w_accept) begin
        r_req <= w_req_in;
      end
      if ((r_state == S_IDLE) || w_gap_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load_sel) begin
        r_selectors[int'(w_tgt_idx)*SEL_WIDTH +: SEL_WIDTH] <= w_tgt_sel;
      end
      if (w_clr_en) begin
        r_enabled[w_tgt_idx] <= 1'b0;
      end
      if (w_set_en) begin
        r_enabled[w_tgt_idx] <= r_req.en;
      end
    end
  end

  assign bus.wr_ready    = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.selectors   = r_selectors;
  assign bus.enabled_out = r_enabled;
  assign bus.done        = r_done;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_mux_config_writer.sv
// Directed bench for mux_config_writer with G=2, plus a background monitor for
// break-before-make ordering and untouched outputs 2/3.
module tb_mux_config_writer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   viol_edge;
  int   viol_stab;
  int   viol_other;

  mux_config_writer_if #(.OUTPUT_COUNT(4), .SEL_WIDTH(4)) bus ();

  mux_config_writer #(
    .INPUT_COUNT (4),
    .OUTPUT_COUNT(4),
    .SEL_WIDTH   (4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call just after a rising edge with the DUT idle; returns 1ns after E0.
  task automatic drive_req(input logic [7:0] idx, input logic [3:0] sel, input logic en);
    bus.wr_valid   = 1'b1;
    bus.wr_out_idx = idx;
    bus.wr_sel     = sel;
    bus.wr_en      = en;
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Enable and selector of one output must never move on the same edge, and an
  // enabled output must keep the selector it was enabled with.
  logic [15:0]      prev_sel;
  logic [3:0]       prev_en;
  logic [3:0][3:0]  en_sel;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sel <= bus.selectors;
      prev_en  <= bus.enabled_out;
      en_sel   <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if ((bus.selectors[k*4 +: 4] != prev_sel[k*4 +: 4]) && (bus.enabled_out[k] != prev_en[k]))
          viol_edge <= viol_edge + 1;
        if (bus.enabled_out[k] && !prev_en[k])
          en_sel[k] <= bus.selectors[k*4 +: 4];
        else if (bus.enabled_out[k] && (bus.selectors[k*4 +: 4] != en_sel[k]))
          viol_stab <= viol_stab + 1;
      end
      if ((bus.selectors[15:8] != 8'h00) || (bus.enabled_out[3:2] != 2'b00))
        viol_other <= viol_other + 1;
      prev_sel <= bus.selectors;
      prev_en  <= bus.enabled_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; failures = 0; viol_edge = 0; viol_stab = 0; viol_other = 0;
    bus.wr_valid = 1'b0; bus.wr_out_idx = 8'd0; bus.wr_sel = 4'd0; bus.wr_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_sel",   32'(bus.selectors),   32'h0);
    check("rst_en",    32'(bus.enabled_out), 32'h0);
    check("rst_ready", 32'(bus.wr_ready),    32'h1);
    check("rst_done",  32'(bus.done),        32'h0);
    check("rst_err",   32'(bus.err),         32'h0);

    // Disabled target: selector at E0, enable + done at E0+2.
    align();
    drive_req(8'd1, 4'd2, 1'b1);
    @(negedge clk);
    check("t2_sel_e0",  32'(bus.selectors),   32'h0020);
    check("t2_en_e0",   32'(bus.enabled_out), 32'h0);
    check("t2_busy_e0", 32'(bus.busy),        32'h1);
    @(negedge clk);
    check("t2_done_e1", 32'(bus.done),        32'h0);
    @(negedge clk);
    check("t2_en_e2",    32'(bus.enabled_out), 32'h2);
    check("t2_done_e2",  32'(bus.done),        32'h1);
    check("t2_ready_e2", 32'(bus.wr_ready),    32'h1);

    // Enabled target: break at E0, selector at E0+2, enable + done at E0+4.
    align();
    drive_req(8'd1, 4'd3, 1'b1);
    @(negedge clk);
    check("t3_en_e0",  32'(bus.enabled_out), 32'h0);
    check("t3_sel_e0", 32'(bus.selectors),   32'h0020);
    @(negedge clk);
    check("t3_sel_e1", 32'(bus.selectors),   32'h0020);
    @(negedge clk);
    check("t3_sel_e2", 32'(bus.selectors),   32'h0030);
    check("t3_en_e2",  32'(bus.enabled_out), 32'h0);
    @(negedge clk);
    check("t3_done_e3", 32'(bus.done),       32'h0);
    @(negedge clk);
    check("t3_en_e4",   32'(bus.enabled_out), 32'h2);
    check("t3_done_e4", 32'(bus.done),        32'h1);
    check("t3_sel_e4",  32'(bus.selectors),   32'h0030);

    // Rejects: bad index, then bad selector.
    align();
    drive_req(8'd4, 4'd1, 1'b1);
    @(negedge clk);
    check("t4a_err",   32'(bus.err),         32'h1);
    check("t4a_ready", 32'(bus.wr_ready),    32'h1);
    check("t4a_sel",   32'(bus.selectors),   32'h0030);
    check("t4a_en",    32'(bus.enabled_out), 32'h2);
    @(negedge clk);
    check("t4a_err_off", 32'(bus.err), 32'h0);
    align();
    drive_req(8'd0, 4'd5, 1'b1);
    @(negedge clk);
    check("t4b_err",   32'(bus.err),         32'h1);
    check("t4b_ready", 32'(bus.wr_ready),    32'h1);
    check("t4b_sel",   32'(bus.selectors),   32'h0030);
    check("t4b_en",    32'(bus.enabled_out), 32'h2);
    @(negedge clk);
    check("t4b_err_off", 32'(bus.err), 32'h0);

    // wr_valid held high: output 0 (disabled) then output 1 (enabled), back to back.
    align();
    bus.wr_valid = 1'b1; bus.wr_out_idx = 8'd0; bus.wr_sel = 4'd1; bus.wr_en = 1'b1;
    @(posedge clk);
    #1 bus.wr_out_idx = 8'd1; bus.wr_sel = 4'd0; bus.wr_en = 1'b1;
    @(negedge clk);
    check("t5_sel_a0",  32'(bus.selectors), 32'h0031);
    check("t5_busy_a0", 32'(bus.busy),      32'h1);
    @(negedge clk);
    @(negedge clk);
    check("t5_done_a2",  32'(bus.done),        32'h1);
    check("t5_ready_a2", 32'(bus.wr_ready),    32'h1);
    check("t5_en_a2",    32'(bus.enabled_out), 32'h3);
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
    @(negedge clk);
    check("t5_en_b0",   32'(bus.enabled_out), 32'h1);
    check("t5_busy_b0", 32'(bus.busy),        32'h1);
    @(negedge clk);
    @(negedge clk);
    check("t5_sel_b2", 32'(bus.selectors),   32'h0001);
    check("t5_en_b2",  32'(bus.enabled_out), 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("t5_en_b4",   32'(bus.enabled_out), 32'h3);
    check("t5_done_b4", 32'(bus.done),        32'h1);

    // en=0 on an enabled output: full sequence, output ends disabled.
    align();
    drive_req(8'd0, 4'd1, 1'b0);
    @(negedge clk);
    check("t6_en_e0", 32'(bus.enabled_out), 32'h2);
    repeat (3) @(negedge clk);
    check("t6_done_e3", 32'(bus.done), 32'h0);
    @(negedge clk);
    check("t6_en_e4",   32'(bus.enabled_out), 32'h2);
    check("t6_sel_e4",  32'(bus.selectors),   32'h0001);
    check("t6_done_e4", 32'(bus.done),        32'h1);

    // Reset in the middle of BREAK.
    align();
    drive_req(8'd1, 4'd2, 1'b1);
    @(negedge clk);
    check("t1_busy", 32'(bus.busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_sel_async", 32'(bus.selectors),   32'h0);
    check("t1_en_async",  32'(bus.enabled_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_sel",   32'(bus.selectors),   32'h0);
    check("t1_en",    32'(bus.enabled_out), 32'h0);
    check("t1_ready", 32'(bus.wr_ready),    32'h1);
    check("t1_done",  32'(bus.done),        32'h0);

    check("mon_same_edge", 32'(viol_edge),  32'h0);
    check("mon_stability", 32'(viol_stab),  32'h0);
    check("mon_untouched", 32'(viol_other), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
